// File: rtl/ctrl_api_pkg.sv
// rtl/ctrl_api_pkg.sv - shared reliability message codes, AXIS widths, tuser layout and route enum
package ctrl_api;

    localparam int PACKET_MSG_TYPE_WIDTH = 8;

    localparam logic [PACKET_MSG_TYPE_WIDTH-1:0] RPM_MSG_TYPE_PUB     = 8'h03;
    localparam logic [PACKET_MSG_TYPE_WIDTH-1:0] RPM_MSG_TYPE_PUBREC  = 8'h05;
    localparam logic [PACKET_MSG_TYPE_WIDTH-1:0] RPM_MSG_TYPE_PUBREL  = 8'h06;
    localparam logic [PACKET_MSG_TYPE_WIDTH-1:0] RPM_MSG_TYPE_PUBCOMP = 8'h07;

    localparam int AXIS_DATA_WIDTH_DEFAULT          = 512;
    localparam int AXIS_KEEP_WIDTH_DEFAULT          = AXIS_DATA_WIDTH_DEFAULT / 8;
    localparam int AXIS_FROM_NB_TDEST_WIDTH_DEFAULT = 8;
    localparam int AXIS_FROM_NB_TUSER_WIDTH_DEFAULT = 64;

    // tuser = {dst_port, src_port, ip_addr}
    localparam int TUSER_IP_OFFSET       = 0;
    localparam int TUSER_IP_WIDTH        = 32;
    localparam int TUSER_SRC_PORT_OFFSET = 32;
    localparam int TUSER_DST_PORT_OFFSET = 48;
    localparam int TUSER_PORT_WIDTH      = 16;

    typedef enum logic [1:0] {
        ROUTE_INBOUND  = 2'd0,
        ROUTE_OUTBOUND = 2'd1,
        ROUTE_DROP     = 2'd2
    } route_e;

endpackage

// File: rtl/rel_msg_type_decoder.sv
// rtl/rel_msg_type_decoder.sv - combinational message type to route decode; RFNBS_DROP_UNKNOWN_EN drops unknown types
module rel_msg_type_decoder
    import ctrl_api::*;
(
    input  logic [PACKET_MSG_TYPE_WIDTH-1:0] msg_type,
    output route_e                           route
);

    always_comb begin
        route = ROUTE_INBOUND;
        case (msg_type)
            RPM_MSG_TYPE_PUB,
            RPM_MSG_TYPE_PUBREL:  route = ROUTE_INBOUND;
            RPM_MSG_TYPE_PUBREC,
            RPM_MSG_TYPE_PUBCOMP: route = ROUTE_OUTBOUND;
`ifdef RFNBS_DROP_UNKNOWN_EN
            default:              route = ROUTE_DROP;
`else
            default:              route = ROUTE_INBOUND;
`endif
        endcase
    end

endmodule

// File: rtl/reliability_from_network_bridge_splitter.sv
// rtl/reliability_from_network_bridge_splitter.sv - zero-latency splitter of network bridge packets to inbound/outbound reliability streams (RFNBS_DROP_UNKNOWN_EN)
module reliability_from_network_bridge_splitter
    import ctrl_api::*;
#(
    parameter int AXIS_DATA_WIDTH          = AXIS_DATA_WIDTH_DEFAULT,
    parameter int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_FROM_NB_TDEST_WIDTH = AXIS_FROM_NB_TDEST_WIDTH_DEFAULT,
    parameter int AXIS_FROM_NB_TUSER_WIDTH = AXIS_FROM_NB_TUSER_WIDTH_DEFAULT
) (
    input  logic                                i_clk,
    input  logic                                i_ap_rst_n,

    input  logic                                from_network_bridge_tvalid,
    output logic                                from_network_bridge_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]          from_network_bridge_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]          from_network_bridge_tkeep,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tid,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tdest,
    input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_network_bridge_tuser,
    input  logic                                from_network_bridge_tlast,

    output logic                                to_rel_outbound_tvalid,
    input  logic                                to_rel_outbound_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_rel_outbound_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_rel_outbound_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rel_outbound_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rel_outbound_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_rel_outbound_tuser,
    output logic                                to_rel_outbound_tlast,

    output logic                                to_rel_inbound_tvalid,
    input  logic                                to_rel_inbound_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_rel_inbound_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_rel_inbound_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rel_inbound_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rel_inbound_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_rel_inbound_tuser,
    output logic                                to_rel_inbound_tlast
);

    logic   in_packet;
    route_e route_q;
    route_e live_route;
    route_e cur_route;
    logic   accept;

    rel_msg_type_decoder u_decoder (
        .msg_type (from_network_bridge_tdata[PACKET_MSG_TYPE_WIDTH-1:0]),
        .route    (live_route)
    );

    // Continuation beats carry payload, so only the first beat is decoded.
    assign cur_route = in_packet ? route_q : live_route;

    // Handshake is gated by reset so nothing is accepted or presented while held.
    always_comb begin
        to_rel_inbound_tvalid      = 1'b0;
        to_rel_outbound_tvalid     = 1'b0;
        from_network_bridge_tready = 1'b0;
        if (i_ap_rst_n) begin
            case (cur_route)
                ROUTE_INBOUND: begin
                    to_rel_inbound_tvalid      = from_network_bridge_tvalid;
                    from_network_bridge_tready = to_rel_inbound_tready;
                end
                ROUTE_OUTBOUND: begin
                    to_rel_outbound_tvalid     = from_network_bridge_tvalid;
                    from_network_bridge_tready = to_rel_outbound_tready;
                end
                ROUTE_DROP: begin
                    from_network_bridge_tready = 1'b1;
                end
                default: begin
                    from_network_bridge_tready = 1'b0;
                end
            endcase
        end
    end

    assign accept = from_network_bridge_tvalid & from_network_bridge_tready;

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            in_packet <= 1'b0;
            route_q   <= ROUTE_INBOUND;
        end else if (accept) begin
            in_packet <= ~from_network_bridge_tlast;
            if (!in_packet) begin
                route_q <= live_route;
            end
        end
    end

    assign to_rel_inbound_tdata  = from_network_bridge_tdata;
    assign to_rel_inbound_tkeep  = from_network_bridge_tkeep;
    assign to_rel_inbound_tid    = from_network_bridge_tid;
    assign to_rel_inbound_tdest  = from_network_bridge_tdest;
    assign to_rel_inbound_tuser  = from_network_bridge_tuser;
    assign to_rel_inbound_tlast  = from_network_bridge_tlast;

    assign to_rel_outbound_tdata = from_network_bridge_tdata;
    assign to_rel_outbound_tkeep = from_network_bridge_tkeep;
    assign to_rel_outbound_tid   = from_network_bridge_tid;
    assign to_rel_outbound_tdest = from_network_bridge_tdest;
    assign to_rel_outbound_tuser = from_network_bridge_tuser;
    assign to_rel_outbound_tlast = from_network_bridge_tlast;

endmodule

// File: tb/tb_reliability_from_network_bridge_splitter.sv
// tb/tb_reliability_from_network_bridge_splitter.sv - directed self-checking bench for the reliability splitter
module tb_reliability_from_network_bridge_splitter;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int TW = 8;
    localparam int UW = 64;

    localparam logic [7:0] T_PUB     = 8'h03;
    localparam logic [7:0] T_PUBREC  = 8'h05;
    localparam logic [7:0] T_PUBREL  = 8'h06;
    localparam logic [7:0] T_PUBCOMP = 8'h07;
    localparam logic [7:0] T_UNKNOWN = 8'hFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          nb_tvalid, nb_tready, nb_tlast;
    logic [DW-1:0] nb_tdata;
    logic [KW-1:0] nb_tkeep;
    logic [TW-1:0] nb_tid, nb_tdest;
    logic [UW-1:0] nb_tuser;
    logic          ob_tvalid, ob_tready, ob_tlast;
    logic [DW-1:0] ob_tdata;
    logic [KW-1:0] ob_tkeep;
    logic [TW-1:0] ob_tid, ob_tdest;
    logic [UW-1:0] ob_tuser;
    logic          ib_tvalid, ib_tready, ib_tlast;
    logic [DW-1:0] ib_tdata;
    logic [KW-1:0] ib_tkeep;
    logic [TW-1:0] ib_tid, ib_tdest;
    logic [UW-1:0] ib_tuser;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reliability_from_network_bridge_splitter dut (
        .i_clk                      (clk),
        .i_ap_rst_n                 (rst_n),
        .from_network_bridge_tvalid (nb_tvalid),
        .from_network_bridge_tready (nb_tready),
        .from_network_bridge_tdata  (nb_tdata),
        .from_network_bridge_tkeep  (nb_tkeep),
        .from_network_bridge_tid    (nb_tid),
        .from_network_bridge_tdest  (nb_tdest),
        .from_network_bridge_tuser  (nb_tuser),
        .from_network_bridge_tlast  (nb_tlast),
        .to_rel_outbound_tvalid     (ob_tvalid),
        .to_rel_outbound_tready     (ob_tready),
        .to_rel_outbound_tdata      (ob_tdata),
        .to_rel_outbound_tkeep      (ob_tkeep),
        .to_rel_outbound_tid        (ob_tid),
        .to_rel_outbound_tdest      (ob_tdest),
        .to_rel_outbound_tuser      (ob_tuser),
        .to_rel_outbound_tlast      (ob_tlast),
        .to_rel_inbound_tvalid      (ib_tvalid),
        .to_rel_inbound_tready      (ib_tready),
        .to_rel_inbound_tdata       (ib_tdata),
        .to_rel_inbound_tkeep       (ib_tkeep),
        .to_rel_inbound_tid         (ib_tid),
        .to_rel_inbound_tdest       (ib_tdest),
        .to_rel_inbound_tuser       (ib_tuser),
        .to_rel_inbound_tlast       (ib_tlast)
    );

    // {inbound tvalid, outbound tvalid, bridge tready}
    function automatic logic [2:0] flags();
        return {ib_tvalid, ob_tvalid, nb_tready};
    endfunction

    // Present one beat at the falling edge; the next rising edge accepts it if tready is high.
    task automatic drive(input logic [7:0] typ, input logic [63:0] pid, input logic [7:0] id,
                         input logic [7:0] dest, input logic [63:0] user, input logic [63:0] keep,
                         input logic last, input logic rin, input logic rout);
        @(negedge clk);
        nb_tdata        = '0;
        nb_tdata[7:0]   = typ;
        nb_tdata[8+:64] = pid;
        nb_tkeep        = keep;
        nb_tid          = id;
        nb_tdest        = dest;
        nb_tuser        = user;
        nb_tlast        = last;
        nb_tvalid       = 1'b1;
        ib_tready       = rin;
        ob_tready       = rout;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        nb_tvalid = 1'b0;
        nb_tlast  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(T_PUB, 64'h1, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold got %b want %b", flags(), 3'b000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL reset_release got %b want %b", flags(), 3'b101);
        end
        idle();
    endtask

    task automatic test_pub();
        drive(T_PUB, 64'hEFEFEFEFEFEFEFEF, 8'hCC, 8'h00, 64'h0C0D0E0F, 64'hA, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (flags() !== 3'b100) begin
            miscompares++;
            $display("FAIL pub_stall got %b want %b", flags(), 3'b100);
        end
        drive(T_PUB, 64'hEFEFEFEFEFEFEFEF, 8'hCC, 8'h00, 64'h0C0D0E0F, 64'hA, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL pub_flip got %b want %b", flags(), 3'b101);
        end
        idle();
    endtask

    task automatic test_pubrec();
        logic [DW-1:0] exp_data;
        logic [UW-1:0] exp_user;
        exp_data        = '0;
        exp_data[7:0]   = T_PUBREC;
        exp_data[8+:64] = 64'hABCDABCD;
        exp_user        = {16'hE0C0, 16'hE0C0, 32'h0};
        drive(T_PUBREC, 64'hABCDABCD, 8'h11, 8'hAB, exp_user, 64'h3, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (flags() !== 3'b011) begin
            miscompares++;
            $display("FAIL pubrec_route got %b want %b", flags(), 3'b011);
        end
        vectors++;
        if (ob_tdata !== exp_data) begin
            miscompares++;
            $display("FAIL pubrec_tdata got %h want %h", ob_tdata[71:0], exp_data[71:0]);
        end
        vectors++;
        if (ob_tdest !== 8'hAB || ob_tid !== 8'h11) begin
            miscompares++;
            $display("FAIL pubrec_tdest_tid got %h/%h want ab/11", ob_tdest, ob_tid);
        end
        vectors++;
        if (ob_tuser !== exp_user) begin
            miscompares++;
            $display("FAIL pubrec_tuser got %h want %h", ob_tuser, exp_user);
        end
        vectors++;
        if (ob_tkeep !== 64'h3 || ob_tlast !== 1'b1) begin
            miscompares++;
            $display("FAIL pubrec_tkeep_tlast got %h/%b want 3/1", ob_tkeep, ob_tlast);
        end
        vectors++;
        if (ib_tdata !== exp_data || ib_tuser !== exp_user) begin
            miscompares++;
            $display("FAIL pubrec_inbound_fields got %h/%h want %h/%h", ib_tdata[71:0], ib_tuser, exp_data[71:0], exp_user);
        end
        idle();
    endtask

    task automatic test_pubrel_pubcomp();
        drive(T_PUBREL, 64'hCDEFCDEF, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (flags() !== 3'b100) begin
            miscompares++;
            $display("FAIL pubrel got %b want %b", flags(), 3'b100);
        end
        drive(T_PUBCOMP, 64'hAEFAAEFA, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (flags() !== 3'b011) begin
            miscompares++;
            $display("FAIL pubcomp got %b want %b", flags(), 3'b011);
        end
        idle();
    endtask

    task automatic test_multibeat();
        drive(T_PUB, 64'h1, 8'h0, 8'h0, 64'h0, 64'hF, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL multi_beat1 got %b want %b", flags(), 3'b101);
        end
        drive(T_PUBCOMP, 64'h2, 8'h0, 8'h0, 64'h0, 64'hF, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (flags() !== 3'b100) begin
            miscompares++;
            $display("FAIL multi_beat2_stall got %b want %b", flags(), 3'b100);
        end
        drive(T_PUBCOMP, 64'h2, 8'h0, 8'h0, 64'h0, 64'hF, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL multi_beat2 got %b want %b", flags(), 3'b101);
        end
        drive(T_PUBREC, 64'h3, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL multi_beat3 got %b want %b", flags(), 3'b101);
        end
        drive(T_PUBCOMP, 64'h4, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b011) begin
            miscompares++;
            $display("FAIL multi_next_pubcomp got %b want %b", flags(), 3'b011);
        end
        idle();
    endtask

    task automatic test_unknown();
`ifdef RFNBS_DROP_UNKNOWN_EN
        drive(T_UNKNOWN, 64'h5, 8'h0, 8'h0, 64'h0, 64'hF, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (flags() !== 3'b001) begin
            miscompares++;
            $display("FAIL unknown_drop_beat1 got %b want %b", flags(), 3'b001);
        end
        drive(T_PUBREC, 64'h6, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (flags() !== 3'b001) begin
            miscompares++;
            $display("FAIL unknown_drop_beat2 got %b want %b", flags(), 3'b001);
        end
`else
        drive(T_UNKNOWN, 64'h5, 8'h0, 8'h0, 64'h0, 64'hF, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (flags() !== 3'b100) begin
            miscompares++;
            $display("FAIL unknown_inbound_stall got %b want %b", flags(), 3'b100);
        end
        drive(T_UNKNOWN, 64'h5, 8'h0, 8'h0, 64'h0, 64'hF, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL unknown_inbound_beat1 got %b want %b", flags(), 3'b101);
        end
        drive(T_PUBREC, 64'h6, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL unknown_inbound_beat2 got %b want %b", flags(), 3'b101);
        end
`endif
        drive(T_PUBCOMP, 64'h7, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b011) begin
            miscompares++;
            $display("FAIL unknown_then_pubcomp got %b want %b", flags(), 3'b011);
        end
        idle();
    endtask

    task automatic test_reset_midpacket();
        drive(T_PUB, 64'h8, 8'h0, 8'h0, 64'h0, 64'hF, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b101) begin
            miscompares++;
            $display("FAIL midreset_beat1 got %b want %b", flags(), 3'b101);
        end
        @(negedge clk);
        nb_tvalid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        drive(T_PUBCOMP, 64'h9, 8'h0, 8'h0, 64'h0, 64'hF, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (flags() !== 3'b011) begin
            miscompares++;
            $display("FAIL midreset_new_packet got %b want %b", flags(), 3'b011);
        end
        idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        nb_tvalid = 1'b0;
        nb_tdata  = '0;
        nb_tkeep  = '0;
        nb_tid    = '0;
        nb_tdest  = '0;
        nb_tuser  = '0;
        nb_tlast  = 1'b0;
        ib_tready = 1'b0;
        ob_tready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_pub();
        test_pubrec();
        test_pubrel_pubcomp();
        test_multibeat();
        test_unknown();
        test_reset_midpacket();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
